// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter, one register per compare-exchange column: STAGES-cycle latency, whole pipe holds on en=0 or output stall.
// Define BITONIC_SORT_INDEX_EN to add out_index, the source lane of every sorted key.
module bitonic_sort_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int N_INPUTS   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*N_INPUTS-1:0]     data_in,
    input  logic                               direction,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*N_INPUTS-1:0]     data_out,
`ifdef BITONIC_SORT_INDEX_EN
    output logic [$clog2(N_INPUTS)*N_INPUTS-1:0] out_index,
`endif
    output logic                               busy
);

    localparam int LOG2N  = $clog2(N_INPUTS);
    localparam int STAGES = LOG2N * (LOG2N + 1) / 2;
    localparam int VEC_W  = DATA_WIDTH * N_INPUTS;

    logic [VEC_W-1:0]  key_q  [STAGES];
    logic [VEC_W-1:0]  key_d  [STAGES];
    logic [VEC_W-1:0]  col_in [STAGES];
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] dir_q, dir_d;
    logic              stall;
    logic              adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = en & ~stall;
    assign in_ready = adv & ~rst;

    // Column s sorts the vector entering register s, so its direction is dir_d[s].
    always_comb begin
        col_in[0] = data_in;
        dir_d[0]  = direction;
        vld_d[0]  = in_valid & in_ready;
        for (int s = 1; s < STAGES; s++) begin
            col_in[s] = key_q[s-1];
            dir_d[s]  = dir_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

`ifdef BITONIC_SORT_INDEX_EN
    localparam int IDX_W = LOG2N * N_INPUTS;

    logic [IDX_W-1:0] idx_q  [STAGES];
    logic [IDX_W-1:0] idx_d  [STAGES];
    logic [IDX_W-1:0] idx_in [STAGES];

    always_comb begin
        for (int k = 0; k < N_INPUTS; k++) begin
            idx_in[0][k*LOG2N +: LOG2N] = LOG2N'(k);
        end
        for (int s = 1; s < STAGES; s++) begin
            idx_in[s] = idx_q[s-1];
        end
    end
`endif

    // Merge block p (sub-sequence size 2^p) has p columns with partner distance 2^(p-1) down to 1.
    for (genvar p = 1; p <= LOG2N; p++) begin : g_merge
        for (genvar r = 0; r < p; r++) begin : g_col
            localparam int S = p * (p - 1) / 2 + r;
            localparam int J = 1 << (p - 1 - r);
            localparam int K = 1 << p;
            for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
                if ((i & J) == 0) begin : g_pair
                    localparam int   L  = i + J;
                    localparam logic UP = ((i & K) == 0);

                    logic [DATA_WIDTH-1:0] ka;
                    logic [DATA_WIDTH-1:0] kb;
                    logic                  asc;
                    logic                  swap;

                    assign ka   = col_in[S][i*DATA_WIDTH +: DATA_WIDTH];
                    assign kb   = col_in[S][L*DATA_WIDTH +: DATA_WIDTH];
                    assign asc  = UP ^ dir_d[S];
                    // Strict compares leave equal keys in place.
                    assign swap = asc ? (ka > kb) : (ka < kb);

                    assign key_d[S][i*DATA_WIDTH +: DATA_WIDTH] = swap ? kb : ka;
                    assign key_d[S][L*DATA_WIDTH +: DATA_WIDTH] = swap ? ka : kb;
`ifdef BITONIC_SORT_INDEX_EN
                    assign idx_d[S][i*LOG2N +: LOG2N] = swap ? idx_in[S][L*LOG2N +: LOG2N]
                                                             : idx_in[S][i*LOG2N +: LOG2N];
                    assign idx_d[S][L*LOG2N +: LOG2N] = swap ? idx_in[S][i*LOG2N +: LOG2N]
                                                             : idx_in[S][L*LOG2N +: LOG2N];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dir_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                key_q[s] <= '0;
`ifdef BITONIC_SORT_INDEX_EN
                idx_q[s] <= '0;
`endif
            end
        end else if (adv) begin
            vld_q <= vld_d;
            dir_q <= dir_d;
            for (int s = 0; s < STAGES; s++) begin
                key_q[s] <= key_d[s];
`ifdef BITONIC_SORT_INDEX_EN
                idx_q[s] <= idx_d[s];
`endif
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign data_out  = key_q[STAGES-1];
    assign busy      = |vld_q;
`ifdef BITONIC_SORT_INDEX_EN
    assign out_index = idx_q[STAGES-1];
`endif

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe at N=8, W=32 with hand-sorted expected vectors.
module tb_bitonic_sort_pipe;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int VW = W * N;

    // Lanes listed 7..0, most significant first.
    localparam logic [VW-1:0] VA      = {32'd5, 32'd7, 32'd4, 32'd1, 32'd0, 32'd6, 32'd3, 32'd2};
    localparam logic [VW-1:0] VA_ASC  = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    localparam logic [VW-1:0] VA_DSC  = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    localparam logic [VW-1:0] VB      = {32'd10, 32'd30, 32'd20, 32'd40, 32'd0, 32'd50, 32'd60, 32'd70};
    localparam logic [VW-1:0] VB_DSC  = {32'd0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70};
    localparam logic [VW-1:0] VC      = {32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'h8000_0000, 32'd3, 32'd2, 32'd2};
    localparam logic [VW-1:0] VC_ASC  = {32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0};
    localparam logic [VW-1:0] VD      = {32'd8, 32'd1, 32'd8, 32'd1, 32'd8, 32'd1, 32'd8, 32'd1};
    localparam logic [VW-1:0] VD_DSC  = {32'd1, 32'd1, 32'd1, 32'd1, 32'd8, 32'd8, 32'd8, 32'd8};
    localparam logic [VW-1:0] VE      = {32'd9, 32'd9, 32'd1, 32'd1, 32'd9, 32'd1, 32'd9, 32'd1};
    localparam logic [VW-1:0] VE_ASC  = {32'd9, 32'd9, 32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'd1};

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] data_in;
    logic          direction;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] data_out;
    logic          busy;
`ifdef BITONIC_SORT_INDEX_EN
    logic [3*N-1:0] out_index;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bitonic_sort_pipe #(.DATA_WIDTH(W), .N_INPUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .direction (direction),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef BITONIC_SORT_INDEX_EN
        .out_index (out_index),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [VW-1:0] v, input logic d);
        in_valid  = 1'b1;
        data_in   = v;
        direction = d;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // n counts edges since the accept edge, already one when called right after send.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [VW-1:0] vin  [4];
        logic [VW-1:0] vexp [4];

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        direction = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", VW'(out_valid), '0);
        check("rst_busy",      VW'(busy),      '0);
        check("rst_data_out",  data_out,       '0);
        check("rst_in_ready",  VW'(in_ready),  '0);
        rst = 1'b0;
        #1 check("idle_in_ready", VW'(in_ready), VW'(1));

        // Single ascending transfer
        send(VA, 1'b0);
        wait_out(n);
        check("asc_latency", VW'(n), VW'(6));
        check("asc_data", data_out, VA_ASC);
`ifdef BITONIC_SORT_INDEX_EN
        check("asc_index", VW'(out_index),
              VW'({3'd6, 3'd2, 3'd7, 3'd5, 3'd1, 3'd0, 3'd4, 3'd3}));
`endif
        @(negedge clk);
        check("asc_valid_after", VW'(out_valid), '0);
        check("asc_busy_after",  VW'(busy),      '0);

        // Single descending transfer
        send(VA, 1'b1);
        wait_out(n);
        check("dsc_latency", VW'(n), VW'(6));
        check("dsc_data", data_out, VA_DSC);
        @(negedge clk);

        // Back-to-back, alternating direction
        vin[0] = VA; vexp[0] = VA_ASC;
        vin[1] = VB; vexp[1] = VB_DSC;
        vin[2] = VC; vexp[2] = VC_ASC;
        vin[3] = VD; vexp[3] = VD_DSC;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            data_in   = vin[i];
            direction = i[0];
            check("b2b_in_ready", VW'(in_ready), VW'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_out(n);
        check("b2b_latency", VW'(n), VW'(3));
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", VW'(out_valid), VW'(1));
            check("b2b_data",  data_out,       vexp[i]);
            @(negedge clk);
        end
        check("b2b_valid_end", VW'(out_valid), '0);

        // Output backpressure for five cycles
        in_valid = 1'b1; data_in = VA; direction = 1'b0;
        @(negedge clk);
        data_in = VB; direction = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    VW'(out_valid), VW'(1));
            check("bp_hold",     data_out,       VA_ASC);
            check("bp_in_ready", VW'(in_ready),  '0);
            if (i == 2) begin
                in_valid = 1'b1; data_in = VC; direction = 1'b0;
            end
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp_still_first", data_out, VA_ASC);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", VW'(out_valid), VW'(1));
        check("bp_second_data",  data_out,       VB_DSC);
        @(negedge clk);
        check("bp_drained", VW'(out_valid), '0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_extra", VW'(seen), '0);

        // en=0 freezes the pipe mid-flight and at the output
        send(VD, 1'b1);
        repeat (2) @(negedge clk);
        en = 1'b0;
        #1 check("en0_in_ready", VW'(in_ready), '0);
        repeat (4) begin
            @(negedge clk);
            check("en0_busy",  VW'(busy),      VW'(1));
            check("en0_valid", VW'(out_valid), '0);
        end
        en = 1'b1;
        wait_out(n);
        check("en0_resume_latency", VW'(n), VW'(4));
        check("en0_data", data_out, VD_DSC);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en0_out_hold_valid", VW'(out_valid), VW'(1));
        check("en0_out_hold_data",  data_out,       VD_DSC);
        en = 1'b1;
        @(negedge clk);
        check("en0_out_drained", VW'(out_valid), '0);

        // Reset with three vectors in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data_in = vin[i]; direction = i[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid",    VW'(out_valid), '0);
        check("midrst_busy",     VW'(busy),      '0);
        check("midrst_data",     data_out,       '0);
        check("midrst_in_ready", VW'(in_ready),  '0);
`ifdef BITONIC_SORT_INDEX_EN
        check("midrst_index", VW'(out_index), '0);
`endif
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("midrst_never_emerge", VW'(seen), '0);

        // Duplicate keys
        send(VE, 1'b0);
        wait_out(n);
        check("dup_latency", VW'(n), VW'(6));
        check("dup_data", data_out, VE_ASC);
`ifdef BITONIC_SORT_INDEX_EN
        begin
            logic [N-1:0] mask;
            int           okc;
            int           idx;
            mask = '0;
            okc  = 1;
            for (int k = 0; k < N; k++) begin
                idx = int'(out_index[k*3 +: 3]);
                mask[idx] = 1'b1;
                if (VE[idx*W +: W] != data_out[k*W +: W]) okc = 0;
            end
            check("dup_index_perm", VW'(mask), VW'(8'hFF));
            check("dup_index_keys", VW'(okc),  VW'(1));
        end
`endif
        @(negedge clk);
        check("dup_busy_after", VW'(busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
